// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - execute stage with HI/LO registers, single-cycle multiply and optional restoring divider
//
// Purpose:
//   Combinational logic/shift/arith/move results for the ex_mem register,
//   plus ownership of the HI/LO pair. MULT/MULTU write HI/LO in one cycle.
//   DIV/DIVU run a one-bit-per-cycle restoring divider that holds the
//   pipeline through stallreq_o.
//
// Build option:
//   EX_DIV_EN - when defined the divider is compiled in; when undefined
//               DIV/DIVU are NOPs and stallreq_o is tied low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aluop_i/alusel_i  operation code and result class
//   reg1_i/reg2_i     operands (rs, rt/immediate)
//   wd_i/wreg_i       destination address / write enable (passed through)
//   flush_i           pipeline flush, aborts a divide
//   wd_o/wreg_o       destination pass-through
//   wdata_o           result of the selected class
//   stallreq_o        freeze request for PC, if_id, id_ex
//   hi_o/lo_o         current HI/LO contents
module ex_muldiv #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stallreq_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   logic_res, shift_res, arith_res, move_res;
  logic [SH_W-1:0]     sh_amt;
  logic [2*DATA_W-1:0] op1_sx, op2_sx, prod_s, prod_u;

  // Divider interface signals, driven by either build variant
  logic                stall_raw;
  logic                div_done_wr;
  logic [DATA_W-1:0]   div_quo_res, div_rem_res;

  assign sh_amt = reg1_i[SH_W-1:0];

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << sh_amt;
      EXE_SRL_OP: shift_res = reg2_i >> sh_amt;
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> sh_amt;
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_q;
      EXE_MFLO_OP: move_res = lo_q;
      default:     move_res = '0;
    endcase
  end

  // Full-width products; explicit extension keeps signedness unambiguous
  assign op1_sx = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i};
  assign op2_sx = {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
  assign prod_s = op1_sx * op2_sx;
  assign prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic              is_div, is_sdiv;
  logic [DATA_W:0]   rem_sh, diff;

  assign is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_sdiv = (aluop_i == EXE_DIV_OP);
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    stall_raw = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div && !flush_i) begin
          stall_raw = 1'b1;
          if (reg2_i == '0) begin
            // Divide by zero: fixed result, no sign correction
            quo_d   = '1;
            rem_d   = reg1_i;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quo_d   = (is_sdiv && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
            dvs_d   = (is_sdiv && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = is_sdiv && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
            rneg_d  = is_sdiv && reg1_i[DATA_W-1];
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        stall_raw = 1'b1;
        // Trial subtract; borrow (diff MSB) means restore the shifted remainder
        if (!diff[DATA_W]) begin
          rem_d = diff[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(DATA_W-1)) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i && (state_q != DIV_IDLE)) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign div_quo_res = qneg_q ? -quo_q : quo_q;
  assign div_rem_res = rneg_q ? -rem_q : rem_q;
  assign div_done_wr = (state_q == DIV_DONE) && !flush_i;
`else
  assign stall_raw   = 1'b0;
  assign div_done_wr = 1'b0;
  assign div_quo_res = '0;
  assign div_rem_res = '0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done_wr) begin
      hi_d = div_rem_res;
      lo_d = div_quo_res;
    end else if (!stall_raw && !flush_i) begin
      case (aluop_i)
        EXE_MTHI_OP:  hi_d = reg1_i;
        EXE_MTLO_OP:  lo_d = reg1_i;
        EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
        EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    wdata_o = '0;
    if (!rst) begin
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_ARITH: wdata_o = arith_res;
        EXE_RES_MOVE:  wdata_o = move_res;
        default:       wdata_o = '0;
      endcase
    end
  end

  assign wd_o       = rst ? '0 : wd_i;
  assign wreg_o     = rst ? 1'b0 : wreg_i;
  assign stallreq_o = rst ? 1'b0 : stall_raw;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        flush;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .flush_i    (flush),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    aluop  = op;
    alusel = sel;
    reg1   = a;
    reg2   = b;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wd = 5'd7; wreg = 1'b1;
    setop(OP_OR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_00FF);
    check("rst_wd", {27'd0, wd_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);
    next(); next();
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    rst = 1'b0;
    #1;

    // Logic, shift, arith
    check("or", wdata_o, 32'h0F0F_00FF);
    check("wd_pass", {27'd0, wd_o}, 32'd7);
    check("wreg_pass", {31'd0, wreg_o}, 32'd1);
    setop(OP_AND, SEL_LOGIC, 32'hF0F0_FFFF, 32'h0FF0_1234); check("and", wdata_o, 32'h00F0_1234);
    setop(OP_XOR, SEL_LOGIC, 32'hFFFF_0000, 32'hF0F0_F0F0); check("xor", wdata_o, 32'h0F0F_F0F0);
    setop(OP_NOR, SEL_LOGIC, 32'h0, 32'h0);                 check("nor", wdata_o, 32'hFFFF_FFFF);
    setop(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);         check("sra", wdata_o, 32'hF800_0000);
    setop(OP_SLL, SEL_SHIFT, 32'd8, 32'h00FF_0001);         check("sll", wdata_o, 32'hFF00_0100);
    setop(OP_SRL, SEL_SHIFT, 32'h23, 32'h8000_0000);        check("srl_amt_low_bits", wdata_o, 32'h1000_0000);
    setop(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2);        check("addu_wrap", wdata_o, 32'd1);
    setop(OP_SUBU, SEL_ARITH, 32'd1, 32'd2);                check("subu_wrap", wdata_o, 32'hFFFF_FFFF);
    setop(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);         check("slt", wdata_o, 32'd1);
    setop(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);        check("sltu", wdata_o, 32'd0);
    setop(OP_OR, 3'b111, 32'h1234_5678, 32'h1);             check("bad_sel", wdata_o, 32'd0);
    setop(8'hEE, SEL_LOGIC, 32'h1234_5678, 32'h1);          check("bad_op", wdata_o, 32'd0);

    // Multiply
    setop(OP_MULT, SEL_NOP, 32'hFFFF_FFFD, 32'd5);
    check("mult_wdata", wdata_o, 32'd0);
    next();
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFF1);
    setop(OP_MULTU, SEL_NOP, 32'hFFFF_FFFF, 32'd2);
    next();
    check("multu_hi", hi_o, 32'd1);
    check("multu_lo", lo_o, 32'hFFFF_FFFE);

    // Moves, and flush suppressing a HI/LO write
    setop(OP_MTHI, SEL_NOP, 32'hA5A5_A5A5, 32'd0); next();
    setop(OP_MTLO, SEL_NOP, 32'h5A5A_5A5A, 32'd0); next();
    setop(OP_MFHI, SEL_MOVE, 32'd0, 32'd0); check("mfhi", wdata_o, 32'hA5A5_A5A5);
    setop(OP_MFLO, SEL_MOVE, 32'd0, 32'd0); check("mflo", wdata_o, 32'h5A5A_5A5A);
    flush = 1'b1;
    setop(OP_MTLO, SEL_NOP, 32'hDEAD_BEEF, 32'd0); next();
    flush = 1'b0;
    check("flush_blocks_mtlo", lo_o, 32'h5A5A_5A5A);

`ifdef EX_DIV_EN
    // DIV -7 / 2
    setop(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2);
    check("div_wdata", wdata_o, 32'd0);
    n = 0;
    while (stallreq_o && n < 50) begin n++; next(); end
    check("div_stall_cycles", n, 32'd33);
    check("div_hi_before_done", hi_o, 32'hA5A5_A5A5);
    next();
    setop(OP_MFLO, SEL_MOVE, 32'd0, 32'd0);
    check("div_mflo", wdata_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);

    // DIV 7 / -2 -> q=-3, r=1
    setop(OP_DIV, SEL_NOP, 32'd7, 32'hFFFF_FFFE);
    n = 0;
    while (stallreq_o && n < 50) begin n++; next(); end
    next();
    check("div_negdvs_lo", lo_o, 32'hFFFF_FFFD);
    check("div_negdvs_hi", hi_o, 32'd1);

    // DIVU 100 / 7
    setop(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    n = 0;
    while (stallreq_o && n < 50) begin n++; next(); end
    check("divu_stall_cycles", n, 32'd33);
    next();
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);

    // DIVU 100 / 0
    setop(OP_DIVU, SEL_NOP, 32'd100, 32'd0);
    check("dbz_stall", {31'd0, stallreq_o}, 32'd1);
    next();
    check("dbz_done_nostall", {31'd0, stallreq_o}, 32'd0);
    next();
    setop(OP_NOP, SEL_NOP, 32'd0, 32'd0);
    check("dbz_lo", lo_o, 32'hFFFF_FFFF);
    check("dbz_hi", hi_o, 32'd100);

    // Flush in BUSY cycle 10
    setop(OP_MTHI, SEL_NOP, 32'h1111_1111, 32'd0); next();
    setop(OP_MTLO, SEL_NOP, 32'h2222_2222, 32'd0); next();
    setop(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) next();
    flush = 1'b1;
    #1;
    check("flush_stall_current", {31'd0, stallreq_o}, 32'd1);
    next();
    flush = 1'b0;
    setop(OP_NOP, SEL_NOP, 32'd0, 32'd0);
    check("flush_idle_nostall", {31'd0, stallreq_o}, 32'd0);
    for (int i = 0; i < 40; i++) next();
    check("flush_hi_kept", hi_o, 32'h1111_1111);
    check("flush_lo_kept", lo_o, 32'h2222_2222);

    // Reset in BUSY cycle 10
    setop(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) next();
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
    next();
    rst = 1'b0;
    setop(OP_NOP, SEL_NOP, 32'd0, 32'd0);
    check("rst_mid_idle", {31'd0, stallreq_o}, 32'd0);
    for (int i = 0; i < 40; i++) next();
    check("rst_mid_hi", hi_o, 32'd0);
    check("rst_mid_lo", lo_o, 32'd0);
`else
    setop(OP_DIV, SEL_NOP, 32'd10, 32'd2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (stallreq_o) n++;
      next();
    end
    check("nodiv_stall", n, 32'd0);
    check("nodiv_wdata", wdata_o, 32'd0);
    check("nodiv_hi", hi_o, 32'hA5A5_A5A5);
    check("nodiv_lo", lo_o, 32'h5A5A_5A5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute stage with HI/LO state and multiplier/divider support. It performs logic, shift, arithmetic, compare and HI/LO-move operations. It owns the HI/LO register pair and runs a multi-cycle restoring divider that stalls the pipeline through `stallreq_o`. It sits between the id_ex and ex_mem pipeline registers. Result and destination outputs are combinational; they are captured by ex_mem.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width. Must be a power of two, ≥8.
- `REG_ADDR_W`, 5, destination register address width.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `aluop_i`  in  8  operation code; `EXE_*_OP` values from defines.v.
- `alusel_i`  in  3  result class: `EXE_RES_LOGIC/SHIFT/ARITH/MOVE/NOP`.
- `reg1_i`  in  DATA_W  operand 1 (rs).
- `reg2_i`  in  DATA_W  operand 2 (rt / immediate).
- `wd_i`  in  REG_ADDR_W  destination register.
- `wreg_i`  in  1  destination write enable.
- `flush_i`  in  1  pipeline flush. Aborts any divide in progress.
- `wd_o`  out  REG_ADDR_W  equals `wd_i`.
- `wreg_o`  out  1  equals `wreg_i`.
- `wdata_o`  out  DATA_W  result of the class selected by `alusel_i`.
- `stallreq_o`  out  1  request to freeze PC, if_id and id_ex.
- `hi_o`, `lo_o`  out  DATA_W  current HI/LO register contents.

## Operation
- Reset (synchronous to `clk` edge): HI=LO=0, divider FSM=IDLE.
  - While `rst`=1, force `wd_o`=0, `wreg_o`=0, `wdata_o`=0 and `stallreq_o`=0.
- Logic ops: OR, AND, XOR, NOR.
- Shift ops: SLL, SRL, SRA.
  - Value shifted is `reg2_i`.
  - Shift amount is `reg1_i[log2(DATA_W)-1:0]`.
  - SRA sign-fills.
- Arith ops:
  - ADDU and SUBU: modulo 2^DATA_W, no overflow trap.
  - SLT (signed) and SLTU (unsigned): result is 1 or 0, zero-extended.
- Move ops:
  - MFHI / MFLO: `wdata_o` = HI / LO register value.
  - MTHI / MTLO: write `reg1_i` into HI / LO at the clock edge.
- MULT (signed) and MULTU (unsigned):
  - Single cycle. Full 2·DATA_W product.
  - HI = upper half, LO = lower half, written at the clock edge.
- HI/LO writes are suppressed in any cycle where `stallreq_o`=1 or `flush_i`=1.
- Unknown `aluop_i` produces 0 in its class. Unknown `alusel_i` gives `wdata_o`=0.

Divider FSM (DIV signed, DIVU unsigned):
- IDLE:
  - On a DIV/DIVU op with `flush_i`=0 and `reg2_i`≠0: load |dividend| and |divisor| (raw values for DIVU), set the iteration counter to 0, assert `stallreq_o`, go to BUSY.
  - If `reg2_i`=0: go to DONE directly with LO=all-ones and HI=`reg1_i`; `stallreq_o`=1 for this cycle.
- BUSY:
  - `stallreq_o`=1. One restoring-division bit per cycle.
  - After DATA_W iterations, go to DONE.
- DONE:
  - `stallreq_o`=0. Apply sign correction for DIV:
    - Quotient is negated if operand signs differ.
    - Remainder takes the sign of the dividend.
  - Write LO=quotient and HI=remainder at the clock edge; go to IDLE.
- `flush_i`=1 in BUSY or DONE: go to IDLE next edge; HI/LO are not written; `stallreq_o` follows the current state for that cycle.
- DIV/DIVU results go to HI/LO only. `wdata_o`=0 for them.

## Timing
- Non-divide ops: zero-latency combinational result. HI/LO effects are visible on `hi_o`/`lo_o` the cycle after.
- Divide:
  - `stallreq_o` is high for DATA_W+1 cycles (1 IDLE-start cycle plus DATA_W BUSY cycles); the instruction occupies EX for DATA_W+2 cycles.
  - HI/LO update at the edge that ends DONE.
- Divide by zero: stall for 1 cycle, 2 cycles total in EX.
- The upstream stage holds all `*_i` inputs stable while `stallreq_o`=1. The block does not re-sample operands after the IDLE cycle.
- An instruction following a divide sees the new HI/LO in its first EX cycle.
- Reset asserted mid-divide: IDLE and HI=LO=0 at that edge; no partial result is written.

## Configuration
- `EX_DIV_EN` defined: divider FSM and datapath are present as described.
- `EX_DIV_EN` undefined: no divider logic is compiled.
  - DIV/DIVU behave as NOPs: no stall, HI/LO unchanged, `wdata_o`=0.
  - `stallreq_o` is tied to 0.

## Test plan
All scenarios use DATA_W=32 with `EX_DIV_EN` defined, except scenario 6.
1. Logic and shift: OR 0x0F0F0000 | 0x000000FF → `wdata_o`=0x0F0F00FF, `wd_o`/`wreg_o` pass through. SRA of 0x80000000 by 4 → 0xF8000000.
2. MULT −3 × 5 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE.
3. DIV −7 / 2 → `stallreq_o` high exactly 33 cycles; after DONE, LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1). MFLO in the next instruction returns 0xFFFFFFFD.
4. DIVU 100 / 0 → 1 stall cycle; then LO=0xFFFFFFFF, HI=100.
5. DIVU 100 / 7 with `flush_i` pulsed in BUSY cycle 10 → IDLE next cycle, `stallreq_o` low, HI/LO unchanged. Repeat with `rst` instead → HI=LO=0.
6. Build without `EX_DIV_EN`: DIV 10 / 2 → `stallreq_o` never rises, HI/LO unchanged, `wdata_o`=0.
